// File: rtl/video_ram_wr_arbiter.sv
// video_ram_wr_arbiter: shares the video index RAM write port between NR
// pixel-compute requesters (round-robin) and a frame-clear sequencer that
// fills addresses 0..IMD-1 with CLR_VAL.
//
// Ports:
//   clk, rst        write clock, asynchronous active-high reset
//   clk_en          clock enable; all state advances only when high
//   clr_start       single-cycle request to start a frame clear
//   clr_busy        high while a clear is in progress
//   clr_done        one-cycle pulse when a clear completes
//   req_vld/adr/dat packed per-requester write requests
//   req_rdy         one-hot grant (combinational)
//   wr_drop         pulse when an accepted request was out of range
//   vram_we/adr_w/dat_w  registered RAM write port
module video_ram_wr_arbiter #(
  parameter int unsigned NR      = 4,
  parameter int unsigned IMAW    = 19,
  parameter int unsigned IMDW    = 8,
  parameter int unsigned IMD     = 480000,
  parameter int unsigned CLR_VAL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 clr_done,
  input  logic [NR-1:0]        req_vld,
  input  logic [NR*IMAW-1:0]   req_adr,
  input  logic [NR*IMDW-1:0]   req_dat,
  output logic [NR-1:0]        req_rdy,
  output logic                 wr_drop,
  output logic                 vram_we,
  output logic [IMAW-1:0]      vram_adr_w,
  output logic [IMDW-1:0]      vram_dat_w
);

  localparam int unsigned PW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   rr_ptr, rr_ptr_n;
  logic [IMAW-1:0] clr_cnt, clr_cnt_n;
  logic            clr_last, clr_last_n;
  logic            busy_n, done_n, drop_n, we_n;
  logic [IMAW-1:0] adr_n;
  logic [IMDW-1:0] dat_n;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [IMAW-1:0] gnt_adr;
  logic [IMDW-1:0] gnt_dat;

  // Rotating-priority search starting at rr_ptr
  always_comb begin : rr_search
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(rr_ptr) + k) % NR;
      if (!gnt_vld && req_vld[PW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  assign gnt_adr = req_adr[32'(gnt_idx)*IMAW +: IMAW];
  assign gnt_dat = req_dat[32'(gnt_idx)*IMDW +: IMDW];

  // Grant is withheld while clearing, while a clear is being requested,
  // and when the clock enable is low
  always_comb begin
    req_rdy = '0;
    if (state == ARB && clk_en && !clr_start && gnt_vld) begin
      req_rdy[gnt_idx] = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    clr_cnt_n  = clr_cnt;
    clr_last_n = clr_last;
    busy_n     = clr_busy;
    done_n     = 1'b0;
    drop_n     = 1'b0;
    we_n       = 1'b0;
    adr_n      = vram_adr_w;
    dat_n      = vram_dat_w;

    case (state)
      ARB: begin
        if (clr_start) begin
          state_n    = CLEAR;
          clr_cnt_n  = '0;
          clr_last_n = 1'b0;
          busy_n     = 1'b1;
        end else if (gnt_vld) begin
          rr_ptr_n = (32'(gnt_idx) == NR - 1) ? '0 : gnt_idx + PW'(1);
          if (32'(gnt_adr) < IMD) begin
            we_n  = 1'b1;
            adr_n = gnt_adr;
            dat_n = gnt_dat;
          end else begin
            drop_n = 1'b1;
          end
        end
      end

      CLEAR: begin
        // clr_last marks the extra cycle after the final write that
        // reports completion and hands the port back
        if (clr_last) begin
          state_n    = ARB;
          clr_last_n = 1'b0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
        end else begin
          we_n  = 1'b1;
          adr_n = clr_cnt;
          dat_n = IMDW'(CLR_VAL);
          if (clr_cnt == IMAW'(IMD - 1)) begin
            clr_last_n = 1'b1;
          end else begin
            clr_cnt_n = clr_cnt + IMAW'(1);
          end
        end
      end

      default: state_n = ARB;
    endcase
  end

  // State and output registers, advanced only on enabled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      clr_cnt    <= '0;
      clr_last   <= 1'b0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      wr_drop    <= 1'b0;
      vram_we    <= 1'b0;
      vram_adr_w <= '0;
      vram_dat_w <= '0;
    end else if (clk_en) begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      clr_cnt    <= clr_cnt_n;
      clr_last   <= clr_last_n;
      clr_busy   <= busy_n;
      clr_done   <= done_n;
      wr_drop    <= drop_n;
      vram_we    <= we_n;
      vram_adr_w <= adr_n;
      vram_dat_w <= dat_n;
    end
  end

endmodule

// File: tb/tb_video_ram_wr_arbiter.sv
// Bench for video_ram_wr_arbiter: a driver applies directed and random
// requests, a reference model predicts grants and queues the expected RAM
// port events, and a monitor pops and compares whenever the RAM would act.
module tb_video_ram_wr_arbiter;

  localparam int unsigned NR      = 4;
  localparam int unsigned IMAW    = 19;
  localparam int unsigned IMDW    = 8;
  localparam int unsigned IMD     = 1000;
  localparam int unsigned CLR_VAL = 'h3C;

  typedef enum int {EV_WR = 0, EV_DROP = 1, EV_DONE = 2} ev_kind_t;

  typedef struct {
    ev_kind_t        kind;
    logic [IMAW-1:0] adr;
    logic [IMDW-1:0] dat;
    bit              clr;
    int unsigned     due;
  } ev_t;

  logic               clk = 1'b1;
  logic               rst = 1'b0;
  logic               clk_en = 1'b0;
  logic               clr_start = 1'b0;
  logic               clr_busy, clr_done;
  logic [NR-1:0]      req_vld = '0;
  logic [NR*IMAW-1:0] req_adr = '0;
  logic [NR*IMDW-1:0] req_dat = '0;
  logic [NR-1:0]      req_rdy;
  logic               wr_drop, vram_we;
  logic [IMAW-1:0]    vram_adr_w;
  logic [IMDW-1:0]    vram_dat_w;

  video_ram_wr_arbiter #(
    .NR(NR), .IMAW(IMAW), .IMDW(IMDW), .IMD(IMD), .CLR_VAL(CLR_VAL)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .req_vld(req_vld), .req_adr(req_adr), .req_dat(req_dat), .req_rdy(req_rdy),
    .wr_drop(wr_drop), .vram_we(vram_we),
    .vram_adr_w(vram_adr_w), .vram_dat_w(vram_dat_w)
  );

  always #5 clk = ~clk;

  ev_t             exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int unsigned     drv_en   = 0;
  int unsigned     mon_en   = 0;
  int              m_ptr    = 0;
  int unsigned     clr_left = 0;
  int              last_gnt = -1;
  bit              cur_vld[NR];
  logic [IMAW-1:0] cur_adr[NR];
  logic [IMDW-1:0] cur_dat[NR];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [IMAW-1:0] a,
                      input logic [IMDW-1:0] d, input bit c, input int unsigned due);
    ev_t e;
    e.kind = k; e.adr = a; e.dat = d; e.clr = c; e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr    = 0;
    clr_left = 0;
  endtask

  // One clock window: apply inputs, check the grant, advance the model
  task automatic step();
    int            g;
    logic [NR-1:0] exp_rdy;
    for (int i = 0; i < NR; i++) begin
      req_vld[i]              = cur_vld[i];
      req_adr[i*IMAW +: IMAW] = cur_adr[i];
      req_dat[i*IMDW +: IMDW] = cur_dat[i];
    end
    #2;
    g       = -1;
    exp_rdy = '0;
    if (!rst && clk_en && clr_left == 0 && !clr_start) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (g < 0 && cur_vld[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_rdy", longint'(req_rdy), longint'(exp_rdy));
    if (!rst && clk_en) begin
      if (clr_left > 0) begin
        clr_left--;
      end else if (clr_start) begin
        // one idle cycle to enter clearing, then IMD writes, then done
        for (int unsigned a = 0; a < IMD; a++)
          push(EV_WR, IMAW'(a), IMDW'(CLR_VAL), 1'b1, drv_en + 2 + a);
        push(EV_DONE, '0, '0, 1'b0, drv_en + 2 + IMD);
        clr_left = IMD + 1;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % NR;
        if (cur_adr[g] < IMD) push(EV_WR, cur_adr[g], cur_dat[g], 1'b0, drv_en + 1);
        else                  push(EV_DROP, '0, '0, 1'b0, drv_en + 1);
      end
    end
    if (clk_en) drv_en++;
    last_gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input ev_kind_t kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: actual kind %0d adr %0h, expected none", kind, vram_adr_w);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", longint'(kind), longint'(e.kind));
    chk("ev_cycle", longint'(mon_en), longint'(e.due));
    if (kind == EV_WR) begin
      chk("vram_adr_w", longint'(vram_adr_w), longint'(e.adr));
      chk("vram_dat_w", longint'(vram_dat_w), longint'(e.dat));
      chk("clr_busy_on_write", longint'(clr_busy), longint'(e.clr));
    end
    if (kind == EV_DONE) chk("clr_busy_on_done", longint'(clr_busy), 0);
  endtask

  // Monitor: an output event counts on each enabled cycle it is presented
  always @(negedge clk) begin
    if (!rst && clk_en) begin
      if (vram_we)  expect_ev(EV_WR);
      if (wr_drop)  expect_ev(EV_DROP);
      if (clr_done) expect_ev(EV_DONE);
      if (exp_q.size() > 0 && exp_q[0].due <= mon_en) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_event: actual none, expected kind %0d adr %0h at cycle %0d",
                 exp_q[0].kind, exp_q[0].adr, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
    if (clk_en) mon_en++;
  end

  function automatic logic [IMAW-1:0] rand_adr();
    case ($urandom_range(0, 7))
      0:       return IMAW'(IMD);
      1:       return IMAW'(IMD - 1);
      2:       return '1;
      3:       return IMAW'($urandom_range(IMD, IMD + 200));
      default: return IMAW'($urandom_range(0, IMD - 1));
    endcase
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      cur_vld[i] = 1'b0; cur_adr[i] = '0; cur_dat[i] = '0;
    end
  endtask

  task automatic run_out_clear();
    for (int c = 0; c < 4000 && clr_left > 0; c++) step();
    chk("clear_finished", longint'(clr_left), 0);
  endtask

  initial begin
    clear_reqs();
    #1;
    // Reset
    rst = 1'b1; clk_en = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("idle_clr_busy", longint'(clr_busy), 0);
      chk("idle_vram_we", longint'(vram_we), 0);
      step();
    end

    // Round-robin with all four requesters held
    for (int i = 0; i < NR; i++) begin
      cur_vld[i] = 1'b1; cur_adr[i] = IMAW'(i * 100); cur_dat[i] = IMDW'(i + 1);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_grant", longint'(last_gnt), longint'(k % 4));
    end

    // Skip idle requesters
    cur_vld[0] = 1'b0; cur_vld[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("skip_grant", longint'(last_gnt), (k % 2 == 0) ? 1 : 3);
    end
    clear_reqs();
    step();

    // Clear with requester 0 waiting; a second clr_start mid-clear is ignored
    cur_vld[0] = 1'b1; cur_adr[0] = IMAW'(5); cur_dat[0] = 8'h77;
    clr_start = 1'b1; step(); clr_start = 1'b0;
    for (int c = 0; c < 4000 && clr_left > 0; c++) begin
      clr_start = (c == 100);
      step();
      clr_start = 1'b0;
    end
    chk("clear_finished", longint'(clr_left), 0);
    chk("clr_done_pulse", longint'(clr_done), 1);
    chk("clr_busy_after", longint'(clr_busy), 0);
    step();
    chk("gnt_on_done_cycle", longint'(last_gnt), 0);
    chk("clr_done_single", longint'(clr_done), 0);
    cur_vld[0] = 1'b0;
    step();

    // Range boundary: IMD drops, IMD-1 writes, all-ones drops, 0 writes
    cur_vld[2] = 1'b1; cur_adr[2] = IMAW'(IMD);     cur_dat[2] = 8'h09; step();
    chk("drop_grant", longint'(last_gnt), 2);
    cur_adr[2] = IMAW'(IMD - 1); cur_dat[2] = 8'h0A; step();
    cur_adr[2] = '1;             cur_dat[2] = 8'h0B; step();
    cur_adr[2] = '0;             cur_dat[2] = 8'h0C; step();
    cur_vld[2] = 1'b0;
    repeat (2) step();

    // Clear under a toggling clock enable, then reset at clr_cnt == 7
    cur_vld[1] = 1'b1; cur_adr[1] = IMAW'(42); cur_dat[1] = 8'h42;
    clr_start = 1'b1; step(); clr_start = 1'b0;
    for (int c = 0; c < 100 && clr_left != IMD - 6; c++) begin
      clk_en = (c % 2 == 1);
      step();
    end
    chk("clr_cnt_reached_7", longint'(clr_left), longint'(IMD - 6));
    clk_en = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_clr_busy", longint'(clr_busy), 0);
    chk("rst_vram_we", longint'(vram_we), 0);
    chk("rst_clr_done", longint'(clr_done), 0);
    model_reset();
    clear_reqs();
    repeat (2) step();
    rst = 1'b0;
    repeat (6) step();

    // Randomised traffic with occasional clears and clock-enable gaps
    for (int c = 0; c < 1500; c++) begin
      clk_en    = ($urandom_range(0, 3) != 0);
      clr_start = ($urandom_range(0, 799) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!cur_vld[i] && $urandom_range(0, 1) == 1) begin
          cur_vld[i] = 1'b1;
          cur_adr[i] = rand_adr();
          cur_dat[i] = IMDW'($urandom_range(0, 255));
        end
      end
      step();
      clr_start = 1'b0;
      if (last_gnt >= 0) cur_vld[last_gnt] = 1'b0;
    end

    // Drain
    clk_en = 1'b1;
    clear_reqs();
    run_out_clear();
    repeat (4) step();
    chk("queue_empty", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
